// File: rtl/bk_sector_seq.sv
// Save-state sector sequencer: turns OSD load/save requests into one slot's worth of
// hps_io sector reads/writes. Define BK_AUTOSAVE_EN to add the autosave_req start input.
module bk_sector_seq #(
    parameter int unsigned SECTORS_LOG2 = 6,
    parameter int unsigned SLOT_BITS    = 2,
    parameter logic [23:0] ACK_TIMEOUT  = 24'd16_000_000
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 downloading,
    input  logic                 img_mounted,
    input  logic                 img_readonly,
    input  logic [63:0]          img_size,
    input  logic                 load_req,
    input  logic                 save_req,
`ifdef BK_AUTOSAVE_EN
    input  logic                 autosave_req,
`endif
    input  logic [SLOT_BITS-1:0] slot,
    input  logic                 sd_ack,
    output logic [31:0]          sd_lba,
    output logic                 sd_rd,
    output logic                 sd_wr,
    output logic                 bk_ena,
    output logic                 bk_loading,
    output logic                 bk_busy,
    output logic                 bk_error
);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_e;

    state_e      state_q, state_d;
    logic [31:0] lba_q, lba_d;
    logic [23:0] wdog_q, wdog_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic        ena_q, ena_d;
    logic        loading_q, loading_d;
    logic        busy_q, busy_d;
    logic        error_q, error_d;
    logic        ack_q, load_q, save_q, dl_q;

    logic loadLvl, saveLvl, loadEdge, saveEdge;
    logic ackRise, ackFall, dlRise, mountOk;
    logic startReq, startLoad, lastSector, wdogExpired;

    assign loadLvl  = load_req & ena_q;
    assign saveLvl  = save_req & ena_q;
    assign loadEdge = loadLvl & ~load_q;
    assign saveEdge = saveLvl & ~save_q;
    assign ackRise  = sd_ack & ~ack_q;
    assign ackFall  = ack_q & ~sd_ack;
    assign dlRise   = downloading & ~dl_q;
    assign mountOk  = downloading & img_mounted & (img_size != 64'd0) & ~img_readonly;

    assign lastSector  = &lba_q[SECTORS_LOG2-1:0];
    assign wdogExpired = (wdog_q + 24'd1) == ACK_TIMEOUT;

`ifdef BK_AUTOSAVE_EN
    // Autosave always writes and only wins when neither OSD request fires this cycle.
    logic autoLvl, auto_q;
    assign autoLvl   = autosave_req & ena_q;
    assign startReq  = loadEdge | saveEdge | (autoLvl & ~auto_q);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) auto_q <= 1'b0;
        else       auto_q <= autoLvl;
    end
`else
    assign startReq  = loadEdge | saveEdge;
`endif
    assign startLoad = loadEdge;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lba_q     <= '0;
            wdog_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            ena_q     <= 1'b0;
            loading_q <= 1'b0;
            busy_q    <= 1'b0;
            error_q   <= 1'b0;
            ack_q     <= 1'b0;
            load_q    <= 1'b0;
            save_q    <= 1'b0;
            dl_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            lba_q     <= lba_d;
            wdog_q    <= wdog_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            ena_q     <= ena_d;
            loading_q <= loading_d;
            busy_q    <= busy_d;
            error_q   <= error_d;
            ack_q     <= sd_ack;
            load_q    <= loadLvl;
            save_q    <= saveLvl;
            dl_q      <= downloading;
        end
    end

    // Abort beats timeout beats the ack handshake; loading_q doubles as the transfer direction.
    always_comb begin
        state_d   = state_q;
        lba_d     = lba_q;
        wdog_d    = '0;
        rd_d      = rd_q;
        wr_d      = wr_q;
        loading_d = loading_q;
        busy_d    = busy_q;
        error_d   = error_q;
        ena_d     = ena_q;

        if (mountOk)     ena_d = 1'b1;
        else if (dlRise) ena_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (startReq) begin
                    state_d   = REQ;
                    lba_d     = 32'(slot) << SECTORS_LOG2;
                    rd_d      = startLoad;
                    wr_d      = ~startLoad;
                    busy_d    = 1'b1;
                    loading_d = startLoad;
                    error_d   = 1'b0;
                end
            end
            REQ, XFER: begin
                wdog_d = wdog_q + 24'd1;
                if (dlRise || wdogExpired) begin
                    state_d   = IDLE;
                    wdog_d    = '0;
                    rd_d      = 1'b0;
                    wr_d      = 1'b0;
                    busy_d    = 1'b0;
                    loading_d = 1'b0;
                    error_d   = ~dlRise;
                end else if (state_q == REQ && ackRise) begin
                    state_d = XFER;
                    wdog_d  = '0;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end else if (state_q == XFER && ackFall) begin
                    wdog_d = '0;
                    if (lastSector) begin
                        state_d   = IDLE;
                        busy_d    = 1'b0;
                        loading_d = 1'b0;
                    end else begin
                        state_d = REQ;
                        lba_d[SECTORS_LOG2-1:0] = lba_q[SECTORS_LOG2-1:0] + SECTORS_LOG2'(1);
                        rd_d    = loading_q;
                        wr_d    = ~loading_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sd_lba     = lba_q;
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_ena     = ena_q;
    assign bk_loading = loading_q;
    assign bk_busy    = busy_q;
    assign bk_error   = error_q;

endmodule
